// File: rtl/led_strip_sequencer.sv
// Frame-level sequencer for the doled LED-frame engine: one start frame, NUM_LEDS
// LED frames read from a synchronous pixel RAM, then END_FRAMES end frames per refresh.
module led_strip_sequencer #(
   parameter int NUM_LEDS   = 60,
   parameter int ADDR_W     = 6,
   parameter int END_FRAMES = 4,
   parameter int ACK_WAIT   = 4
) (
   input  logic              strip_clk,
   input  logic              strip_rst_n,
   input  logic              frame_go,
   output logic              frame_busy,
   output logic              frame_done,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [23:0]       pixel_data,
   output logic [7:0]        led_blue,
   output logic [7:0]        led_green,
   output logic [7:0]        led_red,
   output logic [1:0]        led_type,
   output logic              led_start,
   input  logic              led_busy
);

   localparam int END_W = (END_FRAMES > 1) ? $clog2(END_FRAMES) : 1;
   localparam int ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
   localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);
   localparam logic [END_W-1:0]  LAST_END = END_W'(END_FRAMES - 1);
   localparam logic [ACK_W-1:0]  LAST_ACK = ACK_W'(ACK_WAIT - 1);
   localparam logic [1:0] TYPE_START = 2'd0;
   localparam logic [1:0] TYPE_LED   = 2'd1;
   localparam logic [1:0] TYPE_END   = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC,
      S_START_ISSUE,
      S_XFER_WAIT,
      S_FETCH,
      S_LOAD,
      S_LED_ISSUE,
      S_END_ISSUE,
      S_DONE
   } state_t;

   state_t            r_state,     w_state_nxt;
   logic              r_pending,   w_pending_nxt;
   logic [ADDR_W-1:0] r_led_idx,   w_led_idx_nxt;
   logic [END_W-1:0]  r_end_cnt,   w_end_cnt_nxt;
   logic [ACK_W-1:0]  r_ack_cnt,   w_ack_cnt_nxt;
   logic              r_busy_seen, w_busy_seen_nxt;
   logic [1:0]        r_type,      w_type_nxt;
   logic [23:0]       r_rgb,       w_rgb_nxt;
   logic              w_xfer_end;

   always_ff @(posedge strip_clk) begin
      if (!strip_rst_n) begin
         r_state     <= S_IDLE;
         r_pending   <= 1'b0;
         r_led_idx   <= '0;
         r_end_cnt   <= '0;
         r_ack_cnt   <= '0;
         r_busy_seen <= 1'b0;
         r_type      <= TYPE_START;
         r_rgb       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pending_nxt;
         r_led_idx   <= w_led_idx_nxt;
         r_end_cnt   <= w_end_cnt_nxt;
         r_ack_cnt   <= w_ack_cnt_nxt;
         r_busy_seen <= w_busy_seen_nxt;
         r_type      <= w_type_nxt;
         r_rgb       <= w_rgb_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pending_nxt   = r_pending;
      w_led_idx_nxt   = r_led_idx;
      w_end_cnt_nxt   = r_end_cnt;
      w_ack_cnt_nxt   = r_ack_cnt;
      w_busy_seen_nxt = r_busy_seen;
      w_type_nxt      = r_type;
      w_rgb_nxt       = r_rgb;
      w_xfer_end      = 1'b0;

      // Requests arriving while a frame is in flight coalesce into one pending refresh.
      if (frame_go) w_pending_nxt = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_led_idx_nxt = '0;
            w_end_cnt_nxt = '0;
            if (frame_go || r_pending) begin
               w_pending_nxt = 1'b0;
               w_state_nxt   = S_SYNC;
            end
         end
         S_SYNC: begin
            if (!led_busy) begin
               w_type_nxt  = TYPE_START;
               w_rgb_nxt   = '0;
               w_state_nxt = S_START_ISSUE;
            end
         end
         S_START_ISSUE, S_LED_ISSUE, S_END_ISSUE: begin
            w_ack_cnt_nxt   = '0;
            w_busy_seen_nxt = 1'b0;
            w_state_nxt     = S_XFER_WAIT;
         end
         S_XFER_WAIT: begin
            if (!r_busy_seen) begin
               if (led_busy)                  w_busy_seen_nxt = 1'b1;
               else if (r_ack_cnt == LAST_ACK) w_xfer_end      = 1'b1;
               else                            w_ack_cnt_nxt   = r_ack_cnt + 1'b1;
            end else if (!led_busy) begin
               w_xfer_end = 1'b1;
            end
            if (w_xfer_end) begin
               case (r_type)
                  TYPE_START: w_state_nxt = S_FETCH;
                  TYPE_LED: begin
                     if (r_led_idx == LAST_LED) begin
                        w_type_nxt  = TYPE_END;
                        w_rgb_nxt   = '0;
                        w_state_nxt = S_END_ISSUE;
                     end else begin
                        w_led_idx_nxt = r_led_idx + 1'b1;
                        w_state_nxt   = S_FETCH;
                     end
                  end
                  default: begin
                     if (r_end_cnt == LAST_END) begin
                        w_state_nxt = S_DONE;
                     end else begin
                        w_end_cnt_nxt = r_end_cnt + 1'b1;
                        w_state_nxt   = S_END_ISSUE;
                     end
                  end
               endcase
            end
         end
         S_FETCH: w_state_nxt = S_LOAD;
         // RAM read data is valid here, one cycle after the address was presented.
         S_LOAD: begin
            w_rgb_nxt   = pixel_data;
            w_type_nxt  = TYPE_LED;
            w_state_nxt = S_LED_ISSUE;
         end
         S_DONE: begin
            w_led_idx_nxt = '0;
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign led_start  = (r_state == S_START_ISSUE) || (r_state == S_LED_ISSUE) ||
                       (r_state == S_END_ISSUE);
   assign frame_done = (r_state == S_DONE);
   assign frame_busy = (r_state != S_IDLE) && (r_state != S_DONE);
   assign pixel_addr = r_led_idx;
   assign led_type   = r_type;
   assign led_red    = r_rgb[23:16];
   assign led_green  = r_rgb[15:8];
   assign led_blue   = r_rgb[7:0];

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Directed bench: a 3-LED strip (basic, ack timeout, coalescing, reset, random busy)
// and a 64-LED strip covering the full address range.
module tb_led_strip_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- instance A: 3 LEDs, 1 end frame ----------------
   logic        go_a, fbusy_a, done_a, start_a, start_q_a;
   logic        busy_a = 1'b0;
   logic [1:0]  addr_a, type_a;
   logic [23:0] data_a;
   logic [7:0]  red_a, green_a, blue_a;

   led_strip_sequencer #(.NUM_LEDS(3), .ADDR_W(2), .END_FRAMES(1), .ACK_WAIT(4)) dut_a (
      .strip_clk(clk), .strip_rst_n(rst_n), .frame_go(go_a), .frame_busy(fbusy_a),
      .frame_done(done_a), .pixel_addr(addr_a), .pixel_data(data_a), .led_blue(blue_a),
      .led_green(green_a), .led_red(red_a), .led_type(type_a), .led_start(start_a),
      .led_busy(busy_a));

   logic [23:0] ram_a [4];
   always @(posedge clk) data_a <= ram_a[addr_a];

   bit ack_en_a = 1'b1;
   bit rand_a   = 1'b0;
   int blen_a   = 16;
   int bcnt_a   = 0;
   always @(posedge clk) begin
      if (start_q_a && ack_en_a) begin
         busy_a <= 1'b1;
         bcnt_a <= (rand_a ? int'($urandom_range(40, 1)) : blen_a) - 1;
      end else if (busy_a) begin
         if (bcnt_a == 0) busy_a <= 1'b0;
         else             bcnt_a <= bcnt_a - 1;
      end
   end

   int          q_type_a[$];
   logic [23:0] q_col_a[$];
   int          q_addr_a[$];
   int          q_t_a[$];
   int          done_t_a[$];
   int          busy_viol_a = 0, stab_err_a = 0, done_bad_a = 0;
   logic        trk_a = 1'b0, busy_prev_a = 1'b0;
   logic [25:0] snap_a = '0;

   always @(negedge clk) begin
      start_q_a   <= start_a;
      busy_prev_a <= busy_a;
      if (start_a) begin
         q_type_a.push_back(int'(type_a));
         q_col_a.push_back({red_a, green_a, blue_a});
         q_addr_a.push_back(int'(addr_a));
         q_t_a.push_back(cyc);
         if (busy_a) busy_viol_a <= busy_viol_a + 1;
         snap_a <= {type_a, red_a, green_a, blue_a};
         trk_a  <= 1'b1;
      end else if (trk_a) begin
         if (busy_prev_a && !busy_a) trk_a <= 1'b0;
         else if ({type_a, red_a, green_a, blue_a} != snap_a) stab_err_a <= stab_err_a + 1;
      end
      if (done_a) begin
         done_t_a.push_back(cyc);
         if (fbusy_a) done_bad_a <= done_bad_a + 1;
      end
   end

   // ---------------- instance B: 64 LEDs, 4 end frames ----------------
   logic        go_b, fbusy_b, done_b, start_b, start_q_b;
   logic        busy_b = 1'b0;
   logic [5:0]  addr_b;
   logic [1:0]  type_b;
   logic [23:0] data_b;
   logic [7:0]  red_b, green_b, blue_b;
   int          bcnt_b = 0;

   led_strip_sequencer #(.NUM_LEDS(64), .ADDR_W(6), .END_FRAMES(4), .ACK_WAIT(4)) dut_b (
      .strip_clk(clk), .strip_rst_n(rst_n), .frame_go(go_b), .frame_busy(fbusy_b),
      .frame_done(done_b), .pixel_addr(addr_b), .pixel_data(data_b), .led_blue(blue_b),
      .led_green(green_b), .led_red(red_b), .led_type(type_b), .led_start(start_b),
      .led_busy(busy_b));

   always @(posedge clk) data_b <= {18'h0, addr_b};

   always @(posedge clk) begin
      if (start_q_b) begin
         busy_b <= 1'b1;
         bcnt_b <= 1;
      end else if (busy_b) begin
         if (bcnt_b == 0) busy_b <= 1'b0;
         else             bcnt_b <= bcnt_b - 1;
      end
   end

   int n_led_b = 0, n_end_b = 0, addr_err_b = 0, col_err_b = 0, order_err_b = 0, bviol_b = 0;
   int q_done_addr_b[$];

   always @(negedge clk) begin
      start_q_b <= start_b;
      if (start_b) begin
         if (busy_b) bviol_b <= bviol_b + 1;
         if (type_b == 2'd1) begin
            n_led_b <= n_led_b + 1;
            if (int'(addr_b) != n_led_b) addr_err_b <= addr_err_b + 1;
            if ({red_b, green_b, blue_b} != {18'h0, addr_b}) col_err_b <= col_err_b + 1;
         end else if (type_b == 2'd2) begin
            n_end_b <= n_end_b + 1;
            if (n_led_b != 64) order_err_b <= order_err_b + 1;
         end
      end
      if (done_b) q_done_addr_b.push_back(int'(addr_b));
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done_a(input int target, input int budget, input string tag);
      int n = 0;
      while (done_t_a.size() < target && n < budget) begin tick(); n++; end
      chk(tag, done_t_a.size() >= target, 1);
   endtask

   task automatic wait_starts_a(input int target, input int budget, input string tag);
      int n = 0;
      while (q_t_a.size() < target && n < budget) begin tick(); n++; end
      chk(tag, q_t_a.size() >= target, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k, bs, bd, bstab, bbv;
      int exp_t[5];
      int exp_iv[4];
      logic [23:0] exp_c[3];

      exp_t  = '{0, 1, 1, 1, 2};
      exp_c  = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
      ram_a[0] = 24'hFF0000; ram_a[1] = 24'h00FF00; ram_a[2] = 24'h0000FF; ram_a[3] = 24'h5A5A5A;
      rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0;
      repeat (3) tick();

      chk("rst_start", start_a, 0);
      chk("rst_fbusy", fbusy_a, 0);
      chk("rst_done",  done_a, 0);
      chk("rst_addr",  addr_a, 0);
      chk("rst_type",  type_a, 0);
      chk("rst_rgb",   {red_a, green_a, blue_a}, 0);
      chk("rst_b_start", start_b, 0);
      rst_n = 1'b1;
      tick();

      // basic frame, busy 16 cycles
      bs = q_t_a.size(); bd = done_t_a.size(); k = cyc;
      go_a = 1'b1; tick(); go_a = 1'b0;
      chk("t1_fbusy_rise", fbusy_a, 1);
      wait_done_a(bd + 1, 400, "t1_done_seen");
      chk("t1_nstarts", q_t_a.size() - bs, 5);
      if (q_t_a.size() >= bs + 5) begin
         chk("t1_first_start", q_t_a[bs] - k, 2);
         for (int i = 0; i < 5; i++) chk($sformatf("t1_type%0d", i), q_type_a[bs+i], exp_t[i]);
         for (int i = 0; i < 3; i++) chk($sformatf("t1_rgb%0d", i), q_col_a[bs+1+i], exp_c[i]);
         for (int i = 0; i < 3; i++) chk($sformatf("t1_addr%0d", i), q_addr_a[bs+1+i], i);
         exp_iv = '{20, 20, 20, 18};
         for (int i = 0; i < 4; i++) chk($sformatf("t1_gap%0d", i), q_t_a[bs+i+1] - q_t_a[bs+i], exp_iv[i]);
         chk("t1_done_lat", done_t_a[bd] - q_t_a[bs+4], 18);
      end
      tick();
      chk("t1_idle_addr",  addr_a, 0);
      chk("t1_idle_fbusy", fbusy_a, 0);

      // ack timeout, plus a request landing in the DONE cycle
      ack_en_a = 1'b0;
      bs = q_t_a.size(); bd = done_t_a.size(); k = cyc;
      go_a = 1'b1; tick(); go_a = 1'b0;
      wait_done_a(bd + 1, 400, "t2_done_seen");
      chk("t2_in_done", done_a, 1);
      go_a = 1'b1; tick(); go_a = 1'b0;
      if (q_t_a.size() >= bs + 5 && done_t_a.size() > bd) begin
         exp_iv = '{7, 7, 7, 5};
         chk("t2_first_start", q_t_a[bs] - k, 2);
         for (int i = 0; i < 4; i++) chk($sformatf("t2_gap%0d", i), q_t_a[bs+i+1] - q_t_a[bs+i], exp_iv[i]);
         chk("t2_done_lat", done_t_a[bd] - q_t_a[bs+4], 5);
      end
      wait_done_a(bd + 2, 400, "t2_done2_seen");
      chk("t2_nstarts", q_t_a.size() - bs, 10);
      if (q_t_a.size() >= bs + 6) chk("t2_restart", q_t_a[bs+5] - done_t_a[bd], 3);

      // coalesced requests
      ack_en_a = 1'b1;
      tick();
      bs = q_t_a.size(); bd = done_t_a.size();
      go_a = 1'b1; tick(); go_a = 1'b0;
      repeat (10) tick(); go_a = 1'b1; tick(); go_a = 1'b0;
      repeat (20) tick(); go_a = 1'b1; tick(); go_a = 1'b0;
      repeat (30) tick(); go_a = 1'b1; tick(); go_a = 1'b0;
      wait_done_a(bd + 2, 600, "t3_done2_seen");
      repeat (150) tick();
      chk("t3_ndone",   done_t_a.size() - bd, 2);
      chk("t3_nstarts", q_t_a.size() - bs, 10);
      if (q_t_a.size() >= bs + 6 && done_t_a.size() > bd) chk("t3_restart", q_t_a[bs+5] - done_t_a[bd], 3);
      chk("t3_done_busy", done_bad_a, 0);

      // reset during the second LED frame while busy is high
      bs = q_t_a.size(); bd = done_t_a.size();
      go_a = 1'b1; tick(); go_a = 1'b0;
      wait_starts_a(bs + 3, 300, "t4_led1_seen");
      repeat (3) tick();
      chk("t4_busy_pre", busy_a, 1);
      rst_n = 1'b0; tick();
      chk("t4_rst_fbusy", fbusy_a, 0);
      chk("t4_rst_start", start_a, 0);
      chk("t4_rst_type",  type_a, 0);
      chk("t4_rst_rgb",   {red_a, green_a, blue_a}, 0);
      chk("t4_rst_addr",  addr_a, 0);
      rst_n = 1'b1; go_a = 1'b1; tick(); go_a = 1'b0;
      chk("t4_sync_fbusy", fbusy_a, 1);
      wait_starts_a(bs + 4, 300, "t4_restart_seen");
      chk("t4_no_done", done_t_a.size() - bd, 0);
      if (q_t_a.size() >= bs + 4) begin
         chk("t4_restart_delay", q_t_a[bs+3] - q_t_a[bs+2], 18);
         chk("t4_restart_type",  q_type_a[bs+3], 0);
      end
      wait_done_a(bd + 1, 400, "t4_done_seen");
      chk("t4_nstarts", q_t_a.size() - bs, 8);

      // randomised busy length, two frames
      rand_a = 1'b1;
      tick();
      bs = q_t_a.size(); bd = done_t_a.size(); bstab = stab_err_a; bbv = busy_viol_a;
      for (int f = 0; f < 2; f++) begin
         go_a = 1'b1; tick(); go_a = 1'b0;
         wait_done_a(bd + f + 1, 800, $sformatf("t5_done%0d_seen", f));
      end
      chk("t5_nstarts", q_t_a.size() - bs, 10);
      if (q_t_a.size() >= bs + 10) begin
         for (int i = 0; i < 5; i++) chk($sformatf("t5_type%0d", i), q_type_a[bs+5+i], exp_t[i]);
         for (int i = 0; i < 3; i++) chk($sformatf("t5_addr%0d", i), q_addr_a[bs+6+i], i);
         for (int i = 0; i < 3; i++) chk($sformatf("t5_rgb%0d", i), q_col_a[bs+1+i], exp_c[i]);
      end
      chk("t5_stability", stab_err_a - bstab, 0);
      chk("t5_busy_viol", busy_viol_a - bbv, 0);
      chk("all_busy_viol_a", busy_viol_a, 0);

      // full address range on the 64-LED instance
      go_b = 1'b1; tick(); go_b = 1'b0;
      begin
         int n = 0;
         while (q_done_addr_b.size() < 1 && n < 2000) begin tick(); n++; end
      end
      chk("t6_done_seen", q_done_addr_b.size(), 1);
      chk("t6_nled",      n_led_b, 64);
      chk("t6_nend",      n_end_b, 4);
      chk("t6_addr_seq",  addr_err_b, 0);
      chk("t6_rgb",       col_err_b, 0);
      chk("t6_order",     order_err_b, 0);
      chk("t6_busy_viol", bviol_b, 0);
      if (q_done_addr_b.size() > 0) chk("t6_last_addr", q_done_addr_b[0], 63);
      tick();
      chk("t6_idle_addr", addr_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_strip_sequencer.md
Name: led_strip_sequencer

Overview:
- Frame-level controller for the doled LED-frame engine.
- On each refresh request it drives one complete strip update through the doled handshake, in this order: one start frame, NUM_LEDS LED frames, then END_FRAMES end frames.
- Pixel colours are read one LED at a time from an external synchronous pixel RAM.
- It sits between the pattern/animation logic and doled, and owns the doled_start / doled_busy handshake.

Parameters:
- NUM_LEDS, 60, number of LEDs on the strip (1..2**ADDR_W).
- ADDR_W, 6, pixel RAM address width.
- END_FRAMES, 4, end frames per update (ceil(NUM_LEDS/16)); 0 is illegal.
- ACK_WAIT, 4, cycles to wait for led_busy to rise after a start pulse before treating the transfer as complete.

Ports:
- strip_clk  in  1  sole clock; shares the doled_clk domain.
- strip_rst_n  in  1  synchronous, active-low reset.
- frame_go  in  1  one-cycle refresh request.
- frame_busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the last end frame completes.
- pixel_addr  out  ADDR_W  pixel RAM read address.
- pixel_data  in  24  {red[23:16], green[15:8], blue[7:0]}; valid exactly 1 cycle after pixel_addr.
- led_blue  out  8  to doled blue_input.
- led_green  out  8  to doled green_input.
- led_red  out  8  to doled red_input.
- led_type  out  2  to doled type_input: 0=START, 1=LED, 2=END.
- led_start  out  1  to doled doled_start; one-cycle pulse.
- led_busy  in  1  from doled doled_busy.

Behaviour:
- Reset (strip_rst_n=0 at a strip_clk edge): all outputs 0, state IDLE, pending flag cleared, counters 0.
- Reset mid-frame aborts the frame immediately; no frame_done is issued.
- State sequence: IDLE -> SYNC -> START_ISSUE -> XFER_WAIT -> FETCH -> LED_ISSUE -> XFER_WAIT -> (FETCH ... per LED) -> END_ISSUE -> XFER_WAIT -> (END_ISSUE ... per end frame) -> DONE -> IDLE.
- IDLE:
  - On frame_go or pending=1: clear pending, set frame_busy=1, go to SYNC.
  - frame_busy rises the cycle after frame_go is sampled.
- SYNC: hold until led_busy=0. This covers doled still shifting a byte from before a reset.
- START_ISSUE: led_type=0, data outputs=0, led_start=1 for exactly one cycle.
- FETCH:
  - pixel_addr = LED index, counting 0..NUM_LEDS-1.
  - Next cycle, latch pixel_data into led_red/led_green/led_blue.
- LED_ISSUE: led_type=1, led_start=1 for one cycle.
- END_ISSUE: led_type=2, data outputs=0, led_start=1 for one cycle; end counter counts 0..END_FRAMES-1.
- XFER_WAIT (shared by all three frame types):
  - Wait for led_busy=1; the ack counter starts at 0 the cycle after led_start.
  - If ACK_WAIT cycles elapse with no busy, the transfer is treated as complete.
  - Once busy has been seen, wait for led_busy=0.
  - Then go to the next FETCH, END_ISSUE or DONE according to the counters.
- Data stability: led_type and the colour outputs stay stable from the led_start cycle until XFER_WAIT exits.
- Start spacing: led_start is never asserted while led_busy=1. At least 1 cycle separates consecutive led_start pulses.
- DONE: frame_done=1 for one cycle and frame_busy=0 the same cycle; go to IDLE.
- frame_go while frame_busy=1:
  - Sets pending, which coalesces any number of requests.
  - The next frame starts from IDLE the cycle after DONE.
  - frame_go in the DONE cycle also sets pending.
- pixel_addr holds its last value outside FETCH and returns to 0 in IDLE.
- Counter wrap: the LED counter compares against NUM_LEDS-1 and never wraps past it. NUM_LEDS=2**ADDR_W is supported.
- Latency, with doled busy for B cycles per frame and acking immediately:
  - Ignoring XFER_WAIT exit overheads: ≈ 2 + (B+2) + NUM_LEDS·(B+4) + END_FRAMES·(B+2) + 1 cycles.
  - Exact count is fixed by the state sequence above.

Test Plan:
- Basic frame: NUM_LEDS=3, END_FRAMES=1, RAM = {0xFF0000, 0x00FF00, 0x0000FF}, doled model busy 16 cycles, frame_go pulse.
  - Expect led_type sequence 0,1,1,1,2.
  - Expect LED frames red/green/blue = FF/00/00, 00/FF/00, 00/00/FF.
  - Expect exactly 5 led_start pulses, each while busy=0, then a single frame_done.
- Ack timeout: doled model never raises busy.
  - Each transfer ends ACK_WAIT=4 cycles after its led_start.
  - Frame still completes with 5 starts and frame_done.
- Coalesced requests: 3 frame_go pulses during an active frame.
  - Exactly one extra frame follows, starting the cycle after the first frame_done.
  - Total 2 frame_done pulses.
- Reset mid-frame: assert strip_rst_n=0 for 1 cycle during the second LED frame while led_busy=1.
  - Outputs go to 0 and no frame_done is issued.
  - A new frame_go waits in SYNC until busy falls, then led_type=0 is issued first.
- Data stability: doled model with randomised busy length 1..40.
  - Assert that led_type and colours never change between led_start and busy falling.
  - Assert that pixel_addr visits 0..NUM_LEDS-1 in order, once each.
- Full address range: NUM_LEDS=64, ADDR_W=6, END_FRAMES=4.
  - 64 LED frames and 4 end frames issued.
  - Last pixel_addr=63 with no wrap to 0 before DONE.
